// File: rtl/spi_trg_pls_gen.sv
// SPI-programmed multi-channel trigger pulse generator: per-channel delay/width, fire/abort by frame.
// Define TRG_PLS_REPEAT_EN to add per-channel pulse repetition (cmd 0x5).
module spi_trg_pls_gen #(
  parameter int CH_NUM  = 5,
  parameter int CNT_W   = 16,
  parameter int SYNC_FF = 2
) (
  input  logic              CLK50M,
  input  logic              RESET,
  input  logic              SPI_CS,
  input  logic              SPI_CLK,
  input  logic              SPI_MOSI,
  output logic [CH_NUM-1:0] TRG_PLS,
  output logic [CH_NUM-1:0] BUSY,
  output logic [CH_NUM-1:0] OVERRUN,
  output logic              FRAME_ERR
);

  localparam logic [3:0] CMD_DLY   = 4'h1;
  localparam logic [3:0] CMD_WID   = 4'h2;
  localparam logic [3:0] CMD_FIRE  = 4'h3;
  localparam logic [3:0] CMD_ABORT = 4'h4;
  localparam logic [3:0] CMD_REP   = 4'h5;
  localparam logic [3:0] CMD_CLR   = 4'h6;

  typedef enum logic [1:0] {ST_IDLE, ST_DELAY, ST_PULSE} ch_state_t;

  logic [SYNC_FF-1:0] r_cs_sync;
  logic [SYNC_FF-1:0] r_sclk_sync;
  logic [SYNC_FF-1:0] r_mosi_sync;

  // CS synchroniser resets to the deselected level so reset release never looks like a frame start
  always_ff @(posedge CLK50M) begin
    if (RESET) begin
      r_cs_sync   <= '1;
      r_sclk_sync <= '0;
      r_mosi_sync <= '0;
    end else begin
      r_cs_sync   <= {r_cs_sync[SYNC_FF-2:0], SPI_CS};
      r_sclk_sync <= {r_sclk_sync[SYNC_FF-2:0], SPI_CLK};
      r_mosi_sync <= {r_mosi_sync[SYNC_FF-2:0], SPI_MOSI};
    end
  end

  logic w_cs_rise, w_cs_fall, w_cs_low, w_sclk_rise, w_mosi;

  assign w_cs_rise   =  r_cs_sync[SYNC_FF-2] & ~r_cs_sync[SYNC_FF-1];
  assign w_cs_fall   = ~r_cs_sync[SYNC_FF-2] &  r_cs_sync[SYNC_FF-1];
  assign w_cs_low    = ~r_cs_sync[SYNC_FF-2];
  assign w_sclk_rise =  r_sclk_sync[SYNC_FF-2] & ~r_sclk_sync[SYNC_FF-1];
  assign w_mosi      =  r_mosi_sync[SYNC_FF-1];

  logic [4:0]  r_bit_cnt;
  logic [23:0] r_shift;
  logic [23:0] r_frame;
  logic        r_cmd_valid;
  logic        r_frame_err;
  logic        w_cmd_err;

  always_ff @(posedge CLK50M) begin
    if (RESET) begin
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_frame     <= '0;
      r_cmd_valid <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_cmd_valid <= 1'b0;
      r_frame_err <= w_cmd_err;
      if (w_cs_fall) begin
        r_bit_cnt <= '0;
        r_shift   <= '0;
      end else if (w_sclk_rise && w_cs_low) begin
        r_shift <= {r_shift[22:0], w_mosi};
        if (r_bit_cnt != 5'd25) r_bit_cnt <= r_bit_cnt + 5'd1;
      end
      if (w_cs_rise) begin
        r_bit_cnt <= '0;
        if (r_bit_cnt == 5'd24) begin
          r_cmd_valid <= 1'b1;
          r_frame     <= r_shift;
        end else if (r_bit_cnt != 5'd0) begin
          r_frame_err <= 1'b1;
        end
      end
    end
  end

  logic [3:0]  w_cmd;
  logic [3:0]  w_ch;
  logic [15:0] w_val;
  logic        w_ch_ok, w_known, w_has_ch;
  logic        w_wr_dly, w_wr_wid, w_fire_cmd, w_abort, w_clr;

  assign w_cmd   = r_frame[23:20];
  assign w_ch    = r_frame[19:16];
  assign w_val   = r_frame[15:0];
  assign w_ch_ok = ({1'b0, w_ch} < 5'(CH_NUM));

`ifdef TRG_PLS_REPEAT_EN
  assign w_known  = (w_cmd >= CMD_DLY) && (w_cmd <= CMD_CLR);
  assign w_has_ch = (w_cmd == CMD_DLY) || (w_cmd == CMD_WID) || (w_cmd == CMD_REP);
`else
  assign w_known  = ((w_cmd >= CMD_DLY) && (w_cmd <= CMD_ABORT)) || (w_cmd == CMD_CLR);
  assign w_has_ch = (w_cmd == CMD_DLY) || (w_cmd == CMD_WID);
`endif

  assign w_cmd_err  = r_cmd_valid & (~w_known | (w_has_ch & ~w_ch_ok));
  assign w_wr_dly   = r_cmd_valid & (w_cmd == CMD_DLY) & w_ch_ok;
  assign w_wr_wid   = r_cmd_valid & (w_cmd == CMD_WID) & w_ch_ok;
  assign w_fire_cmd = r_cmd_valid & (w_cmd == CMD_FIRE);
  assign w_abort    = r_cmd_valid & (w_cmd == CMD_ABORT);
  assign w_clr      = r_cmd_valid & (w_cmd == CMD_CLR);

  for (genvar gi = 0; gi < CH_NUM; gi++) begin : g_ch
    logic [CNT_W-1:0] r_delay, r_width, r_cnt, r_lat_wid;
    logic             r_trg, r_busy, r_ovr;
    ch_state_t        r_state;
    logic             w_sel, w_fire;

    assign w_sel  = (w_ch == 4'(gi));
    assign w_fire = w_fire_cmd & w_val[gi];

`ifdef TRG_PLS_REPEAT_EN
    logic [7:0]       r_rep, r_rep_left;
    logic [CNT_W-1:0] r_lat_dly;

    always_ff @(posedge CLK50M) begin
      if (RESET)                                             r_rep <= '0;
      else if (r_cmd_valid && w_cmd == CMD_REP && w_ch_ok && w_sel) r_rep <= w_val[7:0];
    end
`endif

    always_ff @(posedge CLK50M) begin
      if (RESET) begin
        r_delay <= '0;
        r_width <= CNT_W'(1);
      end else begin
        if (w_wr_dly && w_sel) r_delay <= w_val[CNT_W-1:0];
        if (w_wr_wid && w_sel) r_width <= w_val[CNT_W-1:0];
      end
    end

    // Delay/width are copied at fire so later writes only affect the next fire
    always_ff @(posedge CLK50M) begin
      if (RESET) begin
        r_state   <= ST_IDLE;
        r_cnt     <= '0;
        r_lat_wid <= '0;
        r_trg     <= 1'b0;
        r_busy    <= 1'b0;
        r_ovr     <= 1'b0;
`ifdef TRG_PLS_REPEAT_EN
        r_rep_left <= '0;
        r_lat_dly  <= '0;
`endif
      end else begin
        if (w_clr)                              r_ovr <= 1'b0;
        else if (w_fire && r_state != ST_IDLE)  r_ovr <= 1'b1;

        if (w_abort) begin
          r_state <= ST_IDLE;
          r_trg   <= 1'b0;
          r_busy  <= 1'b0;
        end else begin
          case (r_state)
            ST_IDLE: begin
              if (w_fire && r_width != '0) begin
                r_busy    <= 1'b1;
                r_lat_wid <= r_width;
`ifdef TRG_PLS_REPEAT_EN
                r_lat_dly  <= r_delay;
                r_rep_left <= r_rep;
`endif
                if (r_delay == '0) begin
                  r_state <= ST_PULSE;
                  r_cnt   <= r_width;
                  r_trg   <= 1'b1;
                end else begin
                  r_state <= ST_DELAY;
                  r_cnt   <= r_delay;
                end
              end
            end
            ST_DELAY: begin
              if (r_cnt == CNT_W'(1)) begin
                r_state <= ST_PULSE;
                r_cnt   <= r_lat_wid;
                r_trg   <= 1'b1;
              end else begin
                r_cnt <= r_cnt - CNT_W'(1);
              end
            end
            ST_PULSE: begin
              if (r_cnt != CNT_W'(1)) begin
                r_cnt <= r_cnt - CNT_W'(1);
              end
`ifdef TRG_PLS_REPEAT_EN
              // A zero delay still needs one low cycle to separate repeated pulses
              else if (r_rep_left != '0) begin
                r_rep_left <= r_rep_left - 8'd1;
                r_state    <= ST_DELAY;
                r_cnt      <= (r_lat_dly == '0) ? CNT_W'(1) : r_lat_dly;
                r_trg      <= 1'b0;
              end
`endif
              else begin
                r_state <= ST_IDLE;
                r_trg   <= 1'b0;
                r_busy  <= 1'b0;
              end
            end
            default: begin
              r_state <= ST_IDLE;
              r_trg   <= 1'b0;
              r_busy  <= 1'b0;
            end
          endcase
        end
      end
    end

    assign TRG_PLS[gi] = r_trg;
    assign BUSY[gi]    = r_busy;
    assign OVERRUN[gi] = r_ovr;
  end

  assign FRAME_ERR = r_frame_err;

endmodule
